key_debounce: RTL and testbench
===============================

# key_debounce

Synchronises and debounces the raw active-low push-button pins of the board before they reach the memory-mapped key device. The key device inverts its input and treats any change as a new key event, so contact bounce would raise spurious ready/overrun bits. This block sits directly upstream and drives that device's DEVICE bus. It delivers one clean level change per physical press or release, plus one-cycle press/release pulses for optional use by the interrupt or debug logic.

## Interface
- KEYS, 4, number of independent key lines
- DEBOUNCE, 250000, cycles a synchronised input must differ continuously from the output before the output follows; legal range 2..2^24
- CNTBITS, $clog2(DEBOUNCE), counter width per key
- CLK  input  1  system clock
- RESET  input  1  reset, asynchronous, active-high
- KEYRAW  input  KEYS  raw pin levels, asynchronous to CLK, active-low (1 = released)
- KEYOUT  output  KEYS  debounced level, same polarity as KEYRAW; connects to the key device's DEVICE port
- PRESS  output  KEYS  one-cycle pulse per key when KEYOUT[i] falls 1->0
- RELEASE  output  KEYS  one-cycle pulse per key when KEYOUT[i] rises 0->1

## Operation
- Each key is handled independently and identically. There is no interaction between bits.
- Synchroniser: a two-flop chain per key, sync1 <= KEYRAW[i], then sync2 <= sync1. Only sync2 is used downstream.
- Per-key FSM with two states, IDLE and SETTLE, and a counter cnt[CNTBITS-1:0].
  - IDLE: sync2 == KEYOUT[i] and cnt == 0. If sync2 != KEYOUT[i], go to SETTLE and set cnt <= 1.
  - SETTLE, sync2 == KEYOUT[i] (bounce back): go to IDLE, cnt <= 0, no pulse.
  - SETTLE, sync2 != KEYOUT[i] and cnt < DEBOUNCE-1: cnt <= cnt+1.
  - SETTLE, sync2 != KEYOUT[i] and cnt == DEBOUNCE-1: KEYOUT[i] <= sync2, cnt <= 0, go to IDLE. Assert PRESS[i] if the new value is 0, otherwise RELEASE[i].
- PRESS and RELEASE are registered and high for exactly one cycle. They are never both high for the same key.
- Counter arithmetic is unsigned. cnt never exceeds DEBOUNCE-1, so no wrap is possible.
- RESET, including mid-SETTLE: sync1, sync2 and KEYOUT go to all 1s (released). All FSMs go to IDLE, cnt to 0, PRESS and RELEASE to 0. A key held down through reset is therefore reported as a press DEBOUNCE+2 cycles after reset deasserts.

## Timing
- Reset values: KEYOUT = {KEYS{1'b1}}, PRESS = 0, RELEASE = 0.
- Latency for a clean level change on KEYRAW[i] that is sampled at clock edge k:
  - sync2 reflects the change after edge k+1.
  - KEYOUT[i] changes at edge k+1+DEBOUNCE.
  - PRESS or RELEASE is high for the cycle following edge k+1+DEBOUNCE, coincident with the first cycle of the new KEYOUT value.
- An input glitch shorter than DEBOUNCE cycles at sync2 never changes KEYOUT. Each return to the old level restarts the count from 0.
- Simultaneous changes on several keys are processed in parallel with identical latency.

## Structure
- Shared package key_pkg holds:
  - the FSM state encoding (IDLE = 1'b0, SETTLE = 1'b1);
  - the key released-level constant (KEY_RELEASED = 1'b1);
  - the DEBOUNCE default, so the top level and the key device agree.
- Sub-module key_debounce_bit implements the synchroniser, FSM, counter and pulses for one key, parameterised by DEBOUNCE and CNTBITS.
- key_debounce instantiates KEYS copies of key_debounce_bit in a generate loop.

## Test plan
All scenarios run with DEBOUNCE = 4.
- Reset: assert RESET with KEYRAW = 4'b0000, release it. KEYOUT = 4'b1111, PRESS = RELEASE = 0 during reset. KEYOUT = 4'b0000 with PRESS = 4'b1111 for one cycle, 6 edges after reset deasserts.
- Clean press: KEYRAW[0] 1->0 before edge k. KEYOUT[0] = 0 after edge k+5, PRESS[0] high for exactly one cycle, RELEASE = 0.
- Bounce: KEYRAW[1] toggles 0,1,0,1 every 2 cycles, then holds 0. KEYOUT[1] stays 1 until 5 edges after the final sampled 0, and PRESS[1] pulses exactly once.
- Sub-threshold glitch: KEYRAW[2] low for 3 cycles, then high. KEYOUT[2] never changes and no pulses occur.
- Parallel and release: press keys 0 and 3 on the same cycle, then release both. PRESS = 4'b1001 once, then RELEASE = 4'b1001 once. Both occur at identical latency.
- Reset mid-SETTLE: assert RESET while cnt = 2 for a key changing 1->0. Outputs return to reset values, no pulse is emitted, and the count restarts from 0 after reset.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debouncer and the memory-mapped key device:
//   - keyState_t   : per-key debounce FSM state encoding
//   - KEY_RELEASED : pin level of a key that is not pressed (pins are active-low)
//   - DEBOUNCE_DEFAULT : default settle time in CLK cycles, so both ends agree
// -----------------------------------------------------------------------------
package key_pkg;

   // Per-key debounce FSM states
   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } keyState_t;

   // Released level of an active-low key pin
   localparam logic KEY_RELEASED = 1'b1;

   // Default settle time in CLK cycles
   localparam int unsigned DEBOUNCE_DEFAULT = 250000;

   // Counter width needed to hold 0..debounce-1
   function automatic int unsigned cntWidth(input int unsigned debounce);
      return (debounce > 1) ? $clog2(debounce) : 1;
   endfunction

endpackage : key_pkg

// File: rtl/key_debounce_bit.sv
// -----------------------------------------------------------------------------
// key_debounce_bit
// Synchroniser, settle counter and press/release pulse generation for a single
// active-low key line.
//
// Ports:
//   CLK      in   system clock
//   RESET    in   asynchronous, active-high reset
//   KEYRAW   in   raw pin level, asynchronous to CLK (1 = released)
//   KEYOUT   out  debounced level, same polarity as KEYRAW
//   PRESS    out  one-cycle pulse when KEYOUT falls 1->0
//   RELEASE  out  one-cycle pulse when KEYOUT rises 0->1
// -----------------------------------------------------------------------------
module key_debounce_bit
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
   parameter int unsigned CNTBITS  = cntWidth(DEBOUNCE)
)(
   input  logic CLK,
   input  logic RESET,
   input  logic KEYRAW,
   output logic KEYOUT,
   output logic PRESS,
   output logic RELEASE
);

   // Last count value before the output is allowed to follow
   localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE - 1);
   localparam logic [CNTBITS-1:0] CNT_ZERO = '0;
   localparam logic [CNTBITS-1:0] CNT_ONE  = CNTBITS'(1);

   logic               sync1;
   logic               sync2;
   keyState_t          state;
   keyState_t          stateNext;
   logic [CNTBITS-1:0] cnt;
   logic [CNTBITS-1:0] cntNext;
   logic               keyOutNext;
   logic               pressNext;
   logic               releaseNext;
   logic               differ;

   // Two-flop synchroniser; only sync2 is used downstream
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1 <= KEY_RELEASED;
         sync2 <= KEY_RELEASED;
      end else begin
         sync1 <= KEYRAW;
         sync2 <= sync1;
      end
   end

   // Synchronised input disagrees with the debounced output
   assign differ = (sync2 != KEYOUT);

   // FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // FSM next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (differ) begin
               stateNext = SETTLE;
            end
         end
         SETTLE: begin
            // Either a bounce back or the settle time has fully elapsed
            if (!differ || (cnt == CNT_LAST)) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // FSM output logic: next values for the counter and registered outputs
   always_comb begin
      cntNext     = cnt;
      keyOutNext  = KEYOUT;
      pressNext   = 1'b0;
      releaseNext = 1'b0;
      case (state)
         IDLE: begin
            cntNext = differ ? CNT_ONE : CNT_ZERO;
         end
         SETTLE: begin
            if (!differ) begin
               // Bounced back to the old level: restart the count
               cntNext = CNT_ZERO;
            end else if (cnt == CNT_LAST) begin
               cntNext     = CNT_ZERO;
               keyOutNext  = sync2;
               pressNext   = ~sync2;
               releaseNext = sync2;
            end else begin
               cntNext = cnt + CNT_ONE;
            end
         end
         default: begin
            cntNext = CNT_ZERO;
         end
      endcase
   end

   // Counter and registered outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt     <= CNT_ZERO;
         KEYOUT  <= KEY_RELEASED;
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
      end else begin
         cnt     <= cntNext;
         KEYOUT  <= keyOutNext;
         PRESS   <= pressNext;
         RELEASE <= releaseNext;
      end
   end

endmodule : key_debounce_bit

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises and debounces KEYS independent active-low push-button pins
// ahead of the memory-mapped key device. Each key gets its own
// key_debounce_bit; there is no interaction between bits.
//
// Ports:
//   CLK      in   system clock
//   RESET    in   asynchronous, active-high reset
//   KEYRAW   in   [KEYS] raw pin levels, asynchronous to CLK (1 = released)
//   KEYOUT   out  [KEYS] debounced levels, drives the key device DEVICE port
//   PRESS    out  [KEYS] one-cycle pulse per key on a debounced 1->0 change
//   RELEASE  out  [KEYS] one-cycle pulse per key on a debounced 0->1 change
// -----------------------------------------------------------------------------
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned KEYS     = 4,
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
   parameter int unsigned CNTBITS  = cntWidth(DEBOUNCE)
)(
   input  logic            CLK,
   input  logic            RESET,
   input  logic [KEYS-1:0] KEYRAW,
   output logic [KEYS-1:0] KEYOUT,
   output logic [KEYS-1:0] PRESS,
   output logic [KEYS-1:0] RELEASE
);

   // One independent debouncer per key line
   for (genvar i = 0; i < KEYS; i++) begin : genKey
      key_debounce_bit #(
         .DEBOUNCE (DEBOUNCE),
         .CNTBITS  (CNTBITS)
      ) uBit (
         .CLK     (CLK),
         .RESET   (RESET),
         .KEYRAW  (KEYRAW[i]),
         .KEYOUT  (KEYOUT[i]),
         .PRESS   (PRESS[i]),
         .RELEASE (RELEASE[i])
      );
   end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Directed and randomised checks of key_debounce with DEBOUNCE = 4 against a
// reference model that tracks, per key, how many consecutive clock edges the
// synchronised pin level has disagreed with the debounced output.
// -----------------------------------------------------------------------------
module tb_key_debounce;

   localparam int unsigned KEYS = 4;
   localparam int unsigned DEB  = 4;

   logic            CLK;
   logic            RESET;
   logic [KEYS-1:0] KEYRAW;
   logic [KEYS-1:0] KEYOUT;
   logic [KEYS-1:0] PRESS;
   logic [KEYS-1:0] RELEASE;

   key_debounce #(
      .KEYS     (KEYS),
      .DEBOUNCE (DEB)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .KEYRAW  (KEYRAW),
      .KEYOUT  (KEYOUT),
      .PRESS   (PRESS),
      .RELEASE (RELEASE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model state
   logic [KEYS-1:0] pinSeen1;   // pin level captured at the last edge
   logic [KEYS-1:0] pinSeen2;   // pin level captured two edges ago
   logic [KEYS-1:0] mOut;
   logic [KEYS-1:0] mPress;
   logic [KEYS-1:0] mRel;
   int              runLen [KEYS];

   int testsRun;
   int failCount;
   int pressCount [KEYS];
   int releaseCount [KEYS];
   int lowCount [KEYS];

   task automatic modelReset();
      pinSeen1 = '1;
      pinSeen2 = '1;
      mOut     = '1;
      mPress   = '0;
      mRel     = '0;
      for (int i = 0; i < KEYS; i++) runLen[i] = 0;
   endtask

   // Output follows once the synchronised level has disagreed for DEB edges in a row
   task automatic modelEdge();
      if (RESET) begin
         modelReset();
      end else begin
         mPress = '0;
         mRel   = '0;
         for (int i = 0; i < KEYS; i++) begin
            if (pinSeen2[i] != mOut[i]) begin
               runLen[i] = runLen[i] + 1;
               if (runLen[i] == DEB) begin
                  mOut[i] = pinSeen2[i];
                  if (pinSeen2[i]) mRel[i] = 1'b1;
                  else             mPress[i] = 1'b1;
                  runLen[i] = 0;
               end
            end else begin
               runLen[i] = 0;
            end
         end
         pinSeen2 = pinSeen1;
         pinSeen1 = KEYRAW;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < KEYS; i++) begin
         pressCount[i]   = 0;
         releaseCount[i] = 0;
         lowCount[i]     = 0;
      end
   endtask

   // One clock edge: advance model, then compare away from the edge
   task automatic tick();
      @(posedge CLK);
      modelEdge();
      #1;
      check("KEYOUT_model",  32'(KEYOUT),  32'(mOut));
      check("PRESS_model",   32'(PRESS),   32'(mPress));
      check("RELEASE_model", 32'(RELEASE), 32'(mRel));
      for (int i = 0; i < KEYS; i++) begin
         if (PRESS[i])    pressCount[i]++;
         if (RELEASE[i])  releaseCount[i]++;
         if (!KEYOUT[i])  lowCount[i]++;
      end
   endtask

   task automatic assertResetNow();
      RESET = 1'b1;
      #1;
      modelReset();
      check("rst_keyout",  32'(KEYOUT),  32'hF);
      check("rst_press",   32'(PRESS),   32'h0);
      check("rst_release", 32'(RELEASE), 32'h0);
   endtask

   initial begin
      logic [KEYS-1:0] r;
      testsRun  = 0;
      failCount = 0;
      clearCounts();
      RESET  = 1'b1;
      KEYRAW = 4'b0000;
      modelReset();
      #1;
      check("rst_keyout",  32'(KEYOUT),  32'hF);
      check("rst_press",   32'(PRESS),   32'h0);
      check("rst_release", 32'(RELEASE), 32'h0);
      repeat (3) tick();

      // Keys held down through reset report a press DEB+2 edges later
      RESET = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         check("held_wait", 32'(KEYOUT), 32'hF);
      end
      tick();
      check("held_out",   32'(KEYOUT), 32'h0);
      check("held_press", 32'(PRESS),  32'hF);
      tick();
      check("held_once",  32'(PRESS),  32'h0);

      KEYRAW = 4'b1111;
      repeat (5) tick();
      tick();
      check("all_release", 32'(RELEASE), 32'hF);
      repeat (3) tick();

      // Clean press on key 0
      KEYRAW = 4'b1110;
      repeat (5) tick();
      check("press0_wait", 32'(KEYOUT), 32'hF);
      tick();
      check("press0_out",   32'(KEYOUT),  32'hE);
      check("press0_pulse", 32'(PRESS),   32'h1);
      check("press0_rel",   32'(RELEASE), 32'h0);
      tick();
      check("press0_once",  32'(PRESS),   32'h0);
      KEYRAW = 4'b1111;
      repeat (8) tick();

      // Bouncing key 1, then held low
      clearCounts();
      KEYRAW = 4'b1101; repeat (2) tick();
      KEYRAW = 4'b1111; repeat (2) tick();
      KEYRAW = 4'b1101; repeat (2) tick();
      KEYRAW = 4'b1111; repeat (2) tick();
      KEYRAW = 4'b1101;
      repeat (5) tick();
      check("bounce_wait", 32'(KEYOUT), 32'hF);
      tick();
      check("bounce_out",  32'(KEYOUT), 32'hD);
      repeat (4) tick();
      check("bounce_presses", 32'(pressCount[1]), 32'd1);
      KEYRAW = 4'b1111;
      repeat (8) tick();

      // Sub-threshold glitch on key 2
      clearCounts();
      KEYRAW = 4'b1011; repeat (3) tick();
      KEYRAW = 4'b1111; repeat (10) tick();
      check("glitch_low",     32'(lowCount[2]),     32'd0);
      check("glitch_press",   32'(pressCount[2]),   32'd0);
      check("glitch_release", 32'(releaseCount[2]), 32'd0);

      // Keys 0 and 3 together, press then release
      clearCounts();
      KEYRAW = 4'b0110;
      repeat (5) tick();
      check("par_press_wait", 32'(PRESS), 32'h0);
      tick();
      check("par_press",     32'(PRESS),  32'h9);
      check("par_press_out", 32'(KEYOUT), 32'h6);
      tick();
      KEYRAW = 4'b1111;
      repeat (5) tick();
      check("par_rel_wait", 32'(RELEASE), 32'h0);
      tick();
      check("par_release", 32'(RELEASE), 32'h9);
      check("par_rel_out", 32'(KEYOUT),  32'hF);
      repeat (2) tick();
      check("par_press_cnt0", 32'(pressCount[0]),   32'd1);
      check("par_press_cnt3", 32'(pressCount[3]),   32'd1);
      check("par_rel_cnt0",   32'(releaseCount[0]), 32'd1);
      check("par_rel_cnt3",   32'(releaseCount[3]), 32'd1);

      // Reset while key 0 is part way through settling
      clearCounts();
      KEYRAW = 4'b1110;
      repeat (4) tick();
      assertResetNow();
      repeat (2) tick();
      RESET = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         check("midrst_wait",  32'(KEYOUT), 32'hF);
         check("midrst_nopls", 32'(PRESS),  32'h0);
      end
      tick();
      check("midrst_out",   32'(KEYOUT), 32'hE);
      check("midrst_press", 32'(PRESS),  32'h1);
      KEYRAW = 4'b1111;
      repeat (8) tick();

      // Random pin activity with occasional resets
      for (int c = 0; c < 600; c++) begin
         r = KEYRAW;
         for (int k = 0; k < KEYS; k++) begin
            if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
         end
         KEYRAW = r;
         if ($urandom_range(0, 149) == 0) begin
            assertResetNow();
            tick();
            RESET = 1'b0;
         end else begin
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule : tb_key_debounce
